mips_if_prefetch: RTL and testbench
===================================

# mips_if_prefetch

Instruction-fetch stage of the 5-stage MIPS32 pipeline, directly upstream of the IF/ID register and the decoder. It owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel with in-order variable-latency responses, and buffers returned instructions in a small prefetch FIFO. It hands instruction/PC pairs to decode with a valid/ready handshake and handles branch/jump redirects by flushing and discarding stale responses.

## Interface
- DEPTH, 4, prefetch FIFO entries and the cap on outstanding-plus-buffered fetches; power of two, 2..16.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- startPC  in  32  boot fetch address, sampled in BOOT.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address; bits [1:0] always 0.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  32  redirect target.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts; deasserted on stall.
- id_instr  out  32  instruction at FIFO head.
- id_pc  out  32  PC of id_instr.

## Operation
- States: BOOT, RUN, FLUSH. Reset enters BOOT.
- BOOT: one cycle; fetch_pc <= {startPC[31:2],2'b00}; -> RUN.
- RUN: imem_req_valid = (outstanding + fifo_count < DEPTH). imem_req_addr = fetch_pc. On req handshake: fetch_pc += 4 (wraps 0xFFFFFFFC -> 0), outstanding++.
- Response in RUN: write {data, pc} to FIFO tail, outstanding--. PC of each entry comes from an in-order PC queue captured at request time.
- FIFO head drives id_instr/id_pc; id_valid = fifo_count != 0. id_valid & id_ready pops.
- Redirect (any state except BOOT): FIFO cleared; fetch_pc <= {redirect_pc[31:2],2'b00}; discard = outstanding after this cycle's request/response events. discard > 0 -> FLUSH, else -> RUN.
- FLUSH: imem_req_valid = 0; every response is dropped and decrements discard; last discard -> RUN next cycle. Redirect in FLUSH reloads fetch_pc, stays in FLUSH.
- Simultaneous events at redirect: a request handshaking that cycle is counted into discard; a response that cycle is dropped; an id handshake that cycle completes (decode owns that instruction).
- imem_rsp_valid with outstanding == 0: ignored; no state change.
- Counters sized clog2(DEPTH+1); never overflow by credit rule.

## Timing
- Reset (async assert): imem_req_valid 0, imem_req_addr 0, id_valid 0, id_instr 0, id_pc 0, FIFO empty, outstanding 0, state BOOT. Deassertion synchronised to next clk edge.
- First request: cycle 2 after reset release (BOOT cycle 1, RUN cycle 2).
- Response-to-id_valid: 1 cycle (registered FIFO write).
- Full throughput: one instruction per cycle with 1-cycle memory and id_ready held high.
- Redirect to first new request: next cycle if discard = 0; else cycle after last discarded response.
- id_instr/id_pc stable while id_valid & !id_ready.

## Configuration
- MIPS_IF_BYPASS_EN defined: when FIFO empty, state RUN, no redirect, and imem_rsp_valid, response drives id_valid/id_instr/id_pc combinationally; if id_ready, it is consumed and not written to FIFO (0-cycle latency). Otherwise written as normal.
- Undefined: no bypass; all outputs from FIFO registers; 1-cycle latency.

## Test plan
- startPC 0x100, 1-cycle memory returning data = addr, id_ready = 1 -> id_pc 0x100,0x104,0x108,... one per cycle, id_instr == id_pc.
- id_ready = 0 for 10 cycles, 3-cycle memory -> outstanding+buffered never exceeds 4; req_valid drops; on release, 4 entries in order with no loss or duplication.
- Two requests outstanding, redirect_pc 0x2000 -> both responses dropped, state FLUSH then RUN, next id_pc 0x2000.
- Redirect to 0x2003 with zero outstanding -> imem_req_addr 0x2000 next cycle, no FLUSH.
- Fetch at 0xFFFFFFFC -> next request 0x00000000; reset asserted mid-stream -> all outputs 0 same cycle, restart at startPC.
- With and without MIPS_IF_BYPASS_EN, empty FIFO, response at cycle N -> id_valid at N vs N+1.

Source files
------------

// File: rtl/mips_if_prefetch.sv
// MIPS32 instruction-fetch stage: fetch PC, in-order imem request/response tracking,
// prefetch FIFO to decode and redirect flush. Define MIPS_IF_BYPASS_EN for empty-FIFO response bypass.
module mips_if_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] startPC,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_wr, fifo_rd, pcq_wr, pcq_rd;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   pcq        [DEPTH];

  logic          req_hs, rsp_hs, rsp_keep, fifo_empty, fifo_wr_en, fifo_pop;
  logic [CW-1:0] outstanding_nxt;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{startPC[1:0], redirect_pc[1:0]};

  always_comb begin
    imem_req_valid  = (state == RUN) &&
                      (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C);
    imem_req_addr   = fetch_pc;
    req_hs          = imem_req_valid & imem_req_ready;
    // Responses with nothing outstanding are spurious and never counted.
    rsp_hs          = imem_rsp_valid & (outstanding != '0);
    rsp_keep        = rsp_hs & (state == RUN) & ~redirect_valid;
    outstanding_nxt = outstanding + CW'(req_hs) - CW'(rsp_hs);
    fifo_empty      = (fifo_count == '0);
`ifdef MIPS_IF_BYPASS_EN
    id_valid   = ~fifo_empty | rsp_keep;
    id_instr   = '0;
    id_pc      = '0;
    if (!fifo_empty) begin
      id_instr = fifo_instr[fifo_rd];
      id_pc    = fifo_pc[fifo_rd];
    end else if (rsp_keep) begin
      id_instr = imem_rsp_data;
      id_pc    = pcq[pcq_rd];
    end
    fifo_wr_en = rsp_keep & ~(fifo_empty & id_ready);
`else
    id_valid   = ~fifo_empty;
    id_instr   = fifo_empty ? '0 : fifo_instr[fifo_rd];
    id_pc      = fifo_empty ? '0 : fifo_pc[fifo_rd];
    fifo_wr_en = rsp_keep;
`endif
    fifo_pop   = id_valid & id_ready & ~fifo_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      fetch_pc    <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      case (state)
        BOOT: begin
          fetch_pc <= {startPC[31:2], 2'b00};
          state    <= RUN;
        end
        default: begin
          outstanding <= outstanding_nxt;
          if (redirect_valid) begin
            // Everything still in flight after this cycle becomes the discard count.
            fetch_pc   <= {redirect_pc[31:2], 2'b00};
            fifo_count <= '0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            pcq_wr     <= '0;
            pcq_rd     <= '0;
            state      <= (outstanding_nxt != '0) ? FLUSH : RUN;
          end else begin
            if (req_hs) begin
              fetch_pc <= fetch_pc + 32'd4;
              pcq_wr   <= pcq_wr + PW'(1);
            end
            if (rsp_keep) pcq_rd <= pcq_rd + PW'(1);
            if (fifo_wr_en) fifo_wr <= fifo_wr + PW'(1);
            if (fifo_pop) fifo_rd <= fifo_rd + PW'(1);
            fifo_count <= fifo_count + CW'(fifo_wr_en) - CW'(fifo_pop);
            if (state == FLUSH && outstanding_nxt == '0) state <= RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs && !redirect_valid) pcq[pcq_wr] <= fetch_pc;
    if (fifo_wr_en) begin
      fifo_instr[fifo_wr] <= imem_rsp_data;
      fifo_pc[fifo_wr]    <= pcq[pcq_rd];
    end
  end

endmodule

// File: tb/tb_mips_if_prefetch.sv
// Directed bench for mips_if_prefetch: in-order variable-latency memory model returning data = addr,
// decode-side pop recorder, and per-scenario tasks with hand-derived expectations.
module tb_mips_if_prefetch;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] startPC = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  bit spur = 1'b0;
  int req_total = 0;
  int pop_total = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          pend_req = 1'b0;
  bit          pend_rsp = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_due = 0;
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];
  int          pop_cyc[$];
  logic [31:0] exp_pc = '0;

  mips_if_prefetch #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .startPC(startPC),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  // Memory model and pop recorder: commit last cycle's events at negedge+1, sample handshakes at negedge+4.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      #1;
      if (pend_rsp) begin
        mq_addr.delete(0);
        mq_due.delete(0);
      end
      if (pend_req) begin
        mq_addr.push_back(pend_addr);
        mq_due.push_back(pend_due);
      end
      pend_req = 1'b0;
      pend_rsp = 1'b0;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq_addr[0];
        pend_rsp       = 1'b1;
      end else if (spur) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      #3;
      if (!reset) begin
        mq_addr.delete();
        mq_due.delete();
        pend_rsp = 1'b0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          pend_req  = 1'b1;
          pend_addr = imem_req_addr;
          pend_due  = cyc + lat;
          req_total++;
        end
        if (id_valid && id_ready) begin
          pop_pc.push_back(id_pc);
          pop_instr.push_back(id_instr);
          pop_cyc.push_back(cyc);
          pop_total++;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_pops();
    pop_pc.delete();
    pop_instr.delete();
    pop_cyc.delete();
  endtask

  task automatic drain(output bit ok);
    imem_req_ready = 1'b0;
    id_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!id_valid && mq_addr.size() == 0 && !pend_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    startPC = 32'h0000_0100;
    step();
    step();
    tests += 5;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
    if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
    if (id_instr !== 32'h0) begin fails++; $display("FAIL rst_id_instr: got %h want 0", id_instr); end
    if (id_pc !== 32'h0) begin fails++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
    reset = 1'b1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    lat = 1;
    #1;
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL boot_req_valid: got %b want 0", imem_req_valid); end
    step();
    tests += 2;
    if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    if (imem_req_addr !== 32'h100) begin fails++; $display("FAIL first_req_addr: got %h want 00000100", imem_req_addr); end
  endtask

  task automatic test_stream();
    int n;
    int span;
    exp_pc = 32'h100;
    clear_pops();
    for (int i = 0; i < 14; i++) step();
    n = pop_pc.size();
    tests++;
    if (n < 10) begin fails++; $display("FAIL stream_count: got %0d pops want >= 10", n); end
    if (n > 1) begin
      span = pop_cyc[n-1] - pop_cyc[0];
      tests++;
      if (span != n - 1) begin fails++; $display("FAIL stream_rate: %0d pops over %0d cycles, want 1 per cycle", n, span + 1); end
    end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL stream_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
  endtask

  task automatic test_back_pressure();
    int maxf;
    int inflight;
    int n;
    id_ready = 1'b0;
    lat = 3;
    maxf = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      inflight = req_total - pop_total;
      if (inflight > maxf) maxf = inflight;
    end
    tests += 5;
    if (maxf != 4) begin fails++; $display("FAIL bp_inflight_max: got %0d want 4", maxf); end
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    if (id_valid !== 1'b1) begin fails++; $display("FAIL bp_id_valid: got %b want 1", id_valid); end
    if (id_pc !== exp_pc) begin fails++; $display("FAIL bp_head_pc: got %h want %h", id_pc, exp_pc); end
    if (pop_pc.size() != 0) begin fails++; $display("FAIL bp_no_pop: got %0d pops want 0", pop_pc.size()); end
    id_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    n = pop_pc.size();
    tests++;
    if (n < 8) begin fails++; $display("FAIL bp_release_count: got %0d pops want >= 8", n); end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL bp_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
  endtask

  task automatic test_redirect_flush();
    bit ok;
    drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL flush_drain: timed out, got busy want idle"); end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL flush_drain_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
    lat = 4;
    imem_req_ready = 1'b1;
    tests++;
    if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL flush_pre_req: got %b want 1", imem_req_valid); end
    step();
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    step();
    redirect_valid = 1'b0;
    lat = 1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests += 2;
      if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL flush_req_valid[%0d]: got %b want 0", i, imem_req_valid); end
      if (id_valid !== 1'b0) begin fails++; $display("FAIL flush_id_valid[%0d]: got %b want 0", i, id_valid); end
      step();
    end
    tests += 3;
    if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL flush_resume_valid: got %b want 1", imem_req_valid); end
    if (imem_req_addr !== 32'h2000) begin fails++; $display("FAIL flush_resume_addr: got %h want 00002000", imem_req_addr); end
    if (pop_pc.size() != 0) begin fails++; $display("FAIL flush_stale_pop: got %0d pops want 0", pop_pc.size()); end
    exp_pc = 32'h2000;
    clear_pops();
    for (int i = 0; i < 6; i++) step();
    tests++;
    if (pop_pc.size() < 3) begin fails++; $display("FAIL flush_after_count: got %0d pops want >= 3", pop_pc.size()); end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL flush_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
  endtask

  task automatic test_redirect_no_discard();
    bit ok;
    drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL nodisc_drain: timed out, got busy want idle"); end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL nodisc_drain_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2003;
    step();
    redirect_valid = 1'b0;
    tests += 3;
    if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL nodisc_req_valid: got %b want 1", imem_req_valid); end
    if (imem_req_addr !== 32'h2000) begin fails++; $display("FAIL nodisc_req_addr: got %h want 00002000", imem_req_addr); end
    if (id_valid !== 1'b0) begin fails++; $display("FAIL nodisc_id_valid: got %b want 0", id_valid); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    lat = 1;
    tests++;
    if (imem_req_addr !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_start_addr: got %h want fffffff8", imem_req_addr); end
    exp_pc = 32'hFFFF_FFF8;
    clear_pops();
    for (int i = 0; i < 8; i++) step();
    tests++;
    if (pop_pc.size() < 4) begin fails++; $display("FAIL wrap_count: got %0d pops want >= 4", pop_pc.size()); end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL wrap_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
  endtask

  task automatic test_reset_midstream();
    startPC = 32'h0000_0403;
    reset = 1'b0;
    #1;
    tests += 5;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_req_valid: got %b want 0", imem_req_valid); end
    if (imem_req_addr !== 32'h0) begin fails++; $display("FAIL mid_rst_req_addr: got %h want 0", imem_req_addr); end
    if (id_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_id_valid: got %b want 0", id_valid); end
    if (id_instr !== 32'h0) begin fails++; $display("FAIL mid_rst_id_instr: got %h want 0", id_instr); end
    if (id_pc !== 32'h0) begin fails++; $display("FAIL mid_rst_id_pc: got %h want 0", id_pc); end
    step();
    step();
    reset = 1'b1;
    clear_pops();
    step();
    tests += 2;
    if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL restart_req_valid: got %b want 1", imem_req_valid); end
    if (imem_req_addr !== 32'h400) begin fails++; $display("FAIL restart_req_addr: got %h want 00000400", imem_req_addr); end
    exp_pc = 32'h400;
    for (int i = 0; i < 8; i++) step();
    tests++;
    if (pop_pc.size() < 4) begin fails++; $display("FAIL restart_count: got %0d pops want >= 4", pop_pc.size()); end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL restart_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
  endtask

  task automatic test_bypass();
    bit ok;
    drain(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL byp_drain: timed out, got busy want idle"); end
    foreach (pop_pc[i]) begin
      tests++;
      if (pop_pc[i] !== exp_pc || pop_instr[i] !== exp_pc) begin
        fails++;
        $display("FAIL byp_drain_seq[%0d]: id_pc=%h id_instr=%h want %h", i, pop_pc[i], pop_instr[i], exp_pc);
      end
      exp_pc += 32'd4;
    end
    clear_pops();
    spur = 1'b1;
    step();
    spur = 1'b0;
    tests++;
    if (id_valid !== 1'b0) begin fails++; $display("FAIL spur_id_valid: got %b want 0", id_valid); end
    step();
    tests += 3;
    if (id_valid !== 1'b0) begin fails++; $display("FAIL spur_after_id_valid: got %b want 0", id_valid); end
    if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL spur_req_valid: got %b want 1", imem_req_valid); end
    if (imem_req_addr !== exp_pc) begin fails++; $display("FAIL spur_req_addr: got %h want %h", imem_req_addr, exp_pc); end
    id_ready = 1'b0;
    lat = 3;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    step();
`ifdef MIPS_IF_BYPASS_EN
    tests += 3;
    if (id_valid !== 1'b1) begin fails++; $display("FAIL byp_cycle_n_valid: got %b want 1", id_valid); end
    if (id_pc !== exp_pc) begin fails++; $display("FAIL byp_cycle_n_pc: got %h want %h", id_pc, exp_pc); end
    if (id_instr !== exp_pc) begin fails++; $display("FAIL byp_cycle_n_instr: got %h want %h", id_instr, exp_pc); end
`else
    tests++;
    if (id_valid !== 1'b0) begin fails++; $display("FAIL nobyp_cycle_n_valid: got %b want 0", id_valid); end
`endif
    step();
    tests += 3;
    if (id_valid !== 1'b1) begin fails++; $display("FAIL byp_cycle_n1_valid: got %b want 1", id_valid); end
    if (id_pc !== exp_pc) begin fails++; $display("FAIL byp_cycle_n1_pc: got %h want %h", id_pc, exp_pc); end
    if (id_instr !== exp_pc) begin fails++; $display("FAIL byp_cycle_n1_instr: got %h want %h", id_instr, exp_pc); end
    id_ready = 1'b1;
    step();
    tests += 2;
    if (pop_pc.size() != 1) begin fails++; $display("FAIL byp_pop_count: got %0d want 1", pop_pc.size()); end
    if (id_valid !== 1'b0) begin fails++; $display("FAIL byp_empty_after: got %b want 0", id_valid); end
    clear_pops();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_redirect_flush();
    test_redirect_no_discard();
    test_wrap();
    test_reset_midstream();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
